// File: rtl/uart_transmitter.sv
// uart_transmitter: valid/ready byte in, start + LSB-first data + optional even parity + stop bits out.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data and stop bits.
module uart_transmitter #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9_600,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_out,
  output logic                 busy
);
  localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(BIT_TICKS);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic line_n;
  logic bit_end;
`ifdef UART_TX_PARITY_EN
  logic par, par_n;
`endif
  assign bit_end = cnt == CW'(BIT_TICKS - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      uart_out <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      sh       <= sh_n;
      uart_out <= line_n;
`ifdef UART_TX_PARITY_EN
      par      <= par_n;
`endif
    end
  end
  // Counter wraps at every bit end, so each state entry starts it from zero.
  always_comb begin
    state_n = state;
    cnt_n   = bit_end ? '0 : cnt + CW'(1);
    idx_n   = idx;
    sh_n    = sh;
`ifdef UART_TX_PARITY_EN
    par_n   = (state == IDLE && tx_valid) ? ^tx_data : par;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (tx_valid) begin
          state_n = START;
          sh_n    = tx_data;
        end
      end
      START: state_n = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        sh_n    = sh >> 1;
        idx_n   = idx == 3'(DATA_BITS - 1) ? '0 : idx + 3'd1;
        state_n = idx == 3'(DATA_BITS - 1) ? AFTER_DATA : DATA;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: state_n = bit_end ? STOP : PARITY;
`endif
      STOP: if (bit_end) begin
        idx_n   = idx == 3'(STOP_BITS - 1) ? '0 : idx + 3'd1;
        state_n = idx == 3'(STOP_BITS - 1) ? IDLE : STOP;
      end
      default: state_n = IDLE;
    endcase
  end
  // Line value is computed from the next state so uart_out is a clean register.
  always_comb begin
    tx_ready = state == IDLE && !rst;
    busy     = state != IDLE;
`ifdef UART_TX_PARITY_EN
    line_n   = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : state_n == PARITY ? par : 1'b1;
`else
    line_n   = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
`endif
  end
endmodule
